// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with single-step operations and a
// start/busy/done sequencer that repeats one shift/rotate op a given number of times.
module universal_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeLoad = 3'b001;
    localparam logic [2:0] ModeShl  = 3'b010;
    localparam logic [2:0] ModeLsr  = 3'b011;
    localparam logic [2:0] ModeRol  = 3'b100;
    localparam logic [2:0] ModeRor  = 3'b101;
    localparam logic [2:0] ModeAsr  = 3'b110;
    localparam logic [2:0] ModeClr  = 3'b111;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             multi_ok;

    // Result of one step of 'op' applied to 'cur'.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            ModeHold: r = cur;
            ModeLoad: r = load;
            ModeShl:  r = {cur[WIDTH-2:0], sl};
            ModeLsr:  r = {sr, cur[WIDTH-1:1]};
            ModeRol:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            ModeRor:  r = {cur[0], cur[WIDTH-1:1]};
            ModeAsr:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            ModeClr:  r = '0;
            default:  r = cur;
        endcase
        return r;
    endfunction

    // Only shifts and rotates may be repeated by the sequencer.
    assign multi_ok = (mode >= ModeShl) && (mode <= ModeAsr);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                q_d   = step_fn(op_q, q_q, d, ser_in_l, ser_in_r);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            default: begin
                // Idle and Done accept new work identically.
                state_d = StIdle;
                if (start && multi_ok) begin
                    op_d    = mode;
                    cnt_d   = amt;
                    state_d = (amt != '0) ? StRun : StDone;
                end else if (en) begin
                    q_d = step_fn(mode, q_q, d, ser_in_l, ser_in_r);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            op_q    <= ModeHold;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q         = q_q;
    assign q_bar     = ~q_q;
    assign ser_out_l = q_q[WIDTH-1];
    assign ser_out_r = q_q[0];
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: arithmetic reference model checked every
// cycle, plus hand-computed literal expectations.
module tb_universal_shift_register;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst, en, start, ser_in_l, ser_in_r;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic [AW-1:0] amt;
    logic [W-1:0]  q, q_bar;
    logic          ser_out_l, ser_out_r, busy, done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    universal_shift_register #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .start    (start),
        .amt      (amt),
        .q        (q),
        .q_bar    (q_bar),
        .ser_out_l(ser_out_l),
        .ser_out_r(ser_out_r),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the register value.
    int unsigned m_q;
    int unsigned m_op;
    int          m_left;
    bit          m_busy, m_done;

    function automatic int unsigned apply(int unsigned op, int unsigned v, int unsigned dd,
                                          bit sl, bit sr);
        int unsigned top;
        top = 2 ** W;
        case (op)
            0: return v;
            1: return dd;
            2: return (v * 2 + sl) % top;
            3: return v / 2 + sr * (top / 2);
            4: return (v * 2) % top + v / (top / 2);
            5: return v / 2 + (v % 2) * (top / 2);
            6: return v / 2 + (v / (top / 2)) * (top / 2);
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q = 0; m_left = 0; m_busy = 0; m_done = 0;
        end else if (m_busy) begin
            m_q    = apply(m_op, m_q, d, ser_in_l, ser_in_r);
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (start && mode >= 2 && mode <= 6) begin
                m_op   = mode;
                m_left = amt;
                if (amt == 0) m_done = 1;
                else m_busy = 1;
            end else if (en) begin
                m_q = apply(mode, m_q, d, ser_in_l, ser_in_r);
            end
        end
    end

    task automatic check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", q, m_q);
            check("model_q_bar", q_bar, (~m_q) & (2 ** W - 1));
            check("model_ser_out_l", ser_out_l, (m_q >> (W - 1)) & 1);
            check("model_ser_out_r", ser_out_r, m_q & 1);
            check("model_busy", busy, m_busy);
            check("model_done", done, m_done);
            check("busy_done_excl", busy & done, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        en = 0; start = 0; mode = 0; amt = 0; ser_in_l = 0; ser_in_r = 0;
    endtask

    task automatic step(logic [2:0] m, logic [W-1:0] dd, logic sl, logic sr);
        en = 1; mode = m; d = dd; ser_in_l = sl; ser_in_r = sr;
        tick();
        idle();
    endtask

    task automatic launch(logic [2:0] m, logic [AW-1:0] n);
        start = 1; mode = m; amt = n;
        tick();
        idle();
    endtask

    initial begin
        idle();
        d = 0; rst = 1;
        @(negedge clk);
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            en = 1'($urandom); start = 1'($urandom); mode = 3'($urandom);
            d = 8'($urandom); amt = 3'($urandom);
            tick();
            chk_en = 1'b1;
        end
        check("rst_q", q, 8'h00);
        check("rst_q_bar", q_bar, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 0; idle();
        tick();
        check("hold_after_rst", q, 8'h00);

        // Single steps.
        step(3'b001, 8'hA5, 0, 0); check("load", q, 8'hA5);
        check("sol_load", ser_out_l, 1); check("sor_load", ser_out_r, 1);
        step(3'b010, 8'h00, 1, 0); check("shl", q, 8'h4B);
        check("sol_shl", ser_out_l, 0); check("sor_shl", ser_out_r, 1);
        step(3'b011, 8'h00, 0, 0); check("lsr", q, 8'h25);
        step(3'b001, 8'h81, 0, 0);
        step(3'b100, 8'h00, 0, 0); check("rol", q, 8'h03);
        step(3'b101, 8'h00, 0, 0); check("ror", q, 8'h81);
        step(3'b001, 8'h90, 0, 0);
        step(3'b110, 8'h00, 0, 0); check("asr", q, 8'hC8);
        check("sol_asr", ser_out_l, 1); check("sor_asr", ser_out_r, 0);
        step(3'b111, 8'h00, 0, 0); check("clear", q, 8'h00);

        // Multi-cycle rotate left by 3 with noise on ignored inputs.
        step(3'b001, 8'h01, 0, 0);
        launch(3'b100, 3);
        check("mc_busy0", busy, 1); check("mc_q0", q, 8'h01);
        for (int i = 0; i < 3; i++) begin
            en = 1; mode = 3'b111; start = 1; amt = 3'($urandom); d = 8'hFF;
            tick();
            check("mc_q_step", q, 8'h01 << (i + 1));
            check("mc_busy_step", busy, (i < 2) ? 1 : 0);
        end
        idle();
        check("mc_done", done, 1);
        tick();
        check("mc_done_clear", done, 0); check("mc_q_final", q, 8'h08);

        // Zero amount and non-shift start.
        launch(3'b010, 0);
        check("amt0_done", done, 1); check("amt0_busy", busy, 0); check("amt0_q", q, 8'h08);
        tick();
        check("amt0_done_clear", done, 0);
        start = 1; en = 1; mode = 3'b001; d = 8'h3C;
        tick();
        idle();
        check("inv_start_q", q, 8'h3C); check("inv_start_busy", busy, 0);
        check("inv_start_done", done, 0);

        // Reset during a running operation.
        step(3'b001, 8'h01, 0, 0);
        launch(3'b100, 7);
        tick(); tick();
        check("abort_pre_q", q, 8'h04);
        rst = 1;
        tick();
        rst = 0;
        check("abort_q", q, 8'h00); check("abort_busy", busy, 0);
        tick();
        check("abort_no_done", done, 0);
        step(3'b001, 8'h01, 0, 0);
        launch(3'b101, 2);
        tick(); tick();
        check("after_abort_q", q, 8'h40); check("after_abort_done", done, 1);
        idle();
        tick();

        // Back-to-back: second op launched in the done cycle.
        step(3'b001, 8'h03, 0, 0);
        launch(3'b010, 1);
        tick();
        check("b2b_done1", done, 1); check("b2b_q1", q, 8'h06);
        start = 1; mode = 3'b011; amt = 2; ser_in_r = 1;
        tick();
        start = 0; mode = 0; amt = 0;
        check("b2b_busy", busy, 1); check("b2b_done_low", done, 0);
        tick();
        check("b2b_q2", q, 8'h83);
        tick();
        check("b2b_q3", q, 8'hC1); check("b2b_done2", done, 1);
        idle();
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
